instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Multicycle instruction fetch engine that acts as the initiator against the word-addressed `InstructionMemory`. It owns the program counter, drives `inst_address`, waits a parameterised number of cycles for `read_data`, then latches it into an instruction register. It presents the instruction to the control FSM through a valid/ack handshake and accepts branch/jump redirects.

## Interface
Parameters:
- `ADDR_W`, default 8: PC and memory address width, word-addressed, increment of 1 per instruction.
- `DATA_W`, default 32: instruction width.
- `MEM_LAT`, default 1: extra wait cycles before `read_data` is sampled (0 to 15).
- `RESET_PC`, default 0: PC value after reset.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `fetch_req`, in, 1: control FSM requests the next instruction.
- `stall`, in, 1: freezes an in-flight fetch.
- `pc_load`, in, 1: redirect strobe for a branch or jump.
- `pc_load_value`, in, ADDR_W: redirect target.
- `inst_address`, out, ADDR_W: registered address to `InstructionMemory`; always equals the PC.
- `read_data`, in, DATA_W: combinational memory output.
- `instr_out`, out, DATA_W: instruction register.
- `instr_pc`, out, ADDR_W: address from which `instr_out` was fetched.
- `instr_valid`, out, 1: `instr_out` is valid and not yet acknowledged.
- `instr_ack`, in, 1: consumer accepts `instr_out`.
- `busy`, out, 1: high in FETCH.
- `pc_wrap`, out, 1: one-cycle pulse when the PC wraps from all-ones to 0.
- `fetch_count`, out, 16: number of completed captures, saturating at 16'hFFFF.

## Operation
- States are IDLE, FETCH and VALID.
- **IDLE**
  - `fetch_req`=1 moves to FETCH and clears the wait counter `wcnt`.
  - Otherwise the state holds.
- **FETCH** (`busy`=1)
  - When `stall`=1, `wcnt` holds and nothing is captured.
  - When `stall`=0 and `wcnt`<MEM_LAT, `wcnt` increments.
  - When `stall`=0 and `wcnt`==MEM_LAT, the capture happens:
    - `instr_out` takes `read_data`.
    - `instr_pc` takes the PC.
    - The PC becomes PC+1, modulo 2^ADDR_W.
    - `fetch_count` increments, saturating.
    - The state moves to VALID.
- **VALID** (`instr_valid`=1)
  - `instr_out` and `instr_pc` hold stable until `instr_ack`.
  - `instr_ack`=1 with `fetch_req`=1 goes directly to FETCH with `wcnt` cleared, giving back-to-back fetches.
  - `instr_ack`=1 with `fetch_req`=0 goes to IDLE.
- **Redirect**: `pc_load`=1 has priority over everything except `rst`, in any state.
  - The PC takes `pc_load_value`.
  - Any in-flight fetch or unacknowledged instruction is discarded: the state goes to IDLE and `instr_valid` falls on the next cycle.
  - `instr_out` and `instr_pc` keep their last values.
  - `fetch_req` and `instr_ack` are ignored in that cycle.
  - `pc_load` does not change `fetch_count`.
- **Wrap**: the PC advances from 2^ADDR_W-1 to 0 only at a capture, and `pc_wrap` pulses high for that one cycle. A redirect to 0 does not pulse `pc_wrap`.
- `instr_ack` is ignored outside VALID.
- `stall` is ignored outside FETCH.

## Timing
- **Reset values**, one cycle after the `rst` edge:
  - State is IDLE and `wcnt` is 0.
  - PC and `inst_address` are RESET_PC.
  - `instr_out`, `instr_pc`, `instr_valid`, `busy`, `pc_wrap` and `fetch_count` are 0.
- A reset mid-fetch aborts without a capture.
- **Fetch latency**: `fetch_req` is sampled at edge E0 in IDLE.
  - `busy` is high from E0 to E(1+MEM_LAT).
  - Capture occurs at edge E(1+MEM_LAT).
  - `instr_valid` is high after E(1+MEM_LAT), i.e. a latency of MEM_LAT+1 cycles, plus one cycle per stalled FETCH cycle.
- **Address timing**: `inst_address` updates on the same edge as the PC. Memory data is therefore stable for at least MEM_LAT+1 cycles before capture, or the FETCH dwell time when a fetch follows a redirect.
- **Back-to-back throughput**: one instruction per MEM_LAT+2 cycles when `instr_ack` is given in the first VALID cycle.
- **Outputs**: `pc_wrap`, `busy` and `instr_valid` are registered or decoded from state only. None of them is combinational from inputs.

## Test plan
The bench memory model returns `read_data` = 32'hC0DE0000 | `inst_address`. MEM_LAT=1 unless noted.
- **Reset then single fetch**: `rst` for 2 cycles, then `fetch_req` for 1 cycle -> `instr_valid` rises 2 cycles later with `instr_out`=32'hC0DE0000, `instr_pc`=0, PC=1 and `fetch_count`=1; the outputs hold until `instr_ack`.
- **Back-to-back fetches**: `fetch_req` and `instr_ack` held high for 5 fetches -> `instr_out` sequence C0DE0000 through C0DE0004, spaced 3 cycles apart, with `fetch_count`=5.
- **Stall**: assert `stall` for 4 cycles during FETCH -> capture is delayed exactly 4 cycles and the captured value is unchanged.
- **Redirect**:
  - `pc_load`=1 with value 8'h40 while in VALID (unacked) -> `instr_valid` drops next cycle, `fetch_count` is unchanged, and the next fetch returns 32'hC0DE0040 with `instr_pc`=8'h40.
  - Repeat the redirect mid-FETCH -> no capture occurs.
- **Wrap**: `pc_load` 8'hFF, then fetch -> `instr_pc`=8'hFF, PC=0 and `pc_wrap` high for exactly 1 cycle; the next fetch returns 32'hC0DE0000.
- **Latency and reset sweeps**:
  - With MEM_LAT=0, latency is 1 cycle.
  - With MEM_LAT=3, latency is 4 cycles.
  - `rst` asserted mid-FETCH -> all outputs at their reset values and no capture.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Multicycle instruction fetch engine: owns the PC, waits MEM_LAT cycles on the
// word-addressed instruction memory, and hands instructions over a valid/ack handshake.
module instr_fetch_unit #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int MEM_LAT  = 1,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic              stall,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_value,
    output logic [ADDR_W-1:0] inst_address,
    input  logic [DATA_W-1:0] read_data,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ack,
    output logic              busy,
    output logic              pc_wrap,
    output logic [15:0]       fetch_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_VALID = 2'd2;

    localparam logic [3:0]        LAT_V      = 4'(MEM_LAT);
    localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [3:0]        wcnt_r;
    logic [3:0]        wcnt_nxt_s;
    logic              capture_s;
    logic [ADDR_W-1:0] pc_r;
    logic [DATA_W-1:0] instr_out_r;
    logic [ADDR_W-1:0] instr_pc_r;
    logic              busy_r;
    logic              valid_r;
    logic              pc_wrap_r;
    logic [15:0]       fetch_count_r;

    // Next-state and wait-counter decode; a redirect overrides every state.
    always_comb begin
        state_nxt_s = state_r;
        wcnt_nxt_s  = wcnt_r;
        capture_s   = 1'b0;
        if (pc_load) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (fetch_req) begin
                        state_nxt_s = ST_FETCH;
                        wcnt_nxt_s  = 4'd0;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    if (stall) begin
                        wcnt_nxt_s = wcnt_r;
                    end else if (wcnt_r < LAT_V) begin
                        wcnt_nxt_s = wcnt_r + 4'd1;
                    end else begin
                        capture_s   = 1'b1;
                        state_nxt_s = ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (instr_ack && fetch_req) begin
                        state_nxt_s = ST_FETCH;
                        wcnt_nxt_s  = 4'd0;
                    end else if (instr_ack) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_VALID;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    wcnt_nxt_s  = 4'd0;
                end
            endcase
        end
    end

    // State, PC and instruction register updates; status flags registered from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            wcnt_r        <= 4'd0;
            pc_r          <= RESET_PC_V;
            instr_out_r   <= '0;
            instr_pc_r    <= '0;
            busy_r        <= 1'b0;
            valid_r       <= 1'b0;
            pc_wrap_r     <= 1'b0;
            fetch_count_r <= 16'd0;
        end else begin
            state_r   <= state_nxt_s;
            wcnt_r    <= wcnt_nxt_s;
            busy_r    <= (state_nxt_s == ST_FETCH);
            valid_r   <= (state_nxt_s == ST_VALID);
            pc_wrap_r <= capture_s && (&pc_r);
            if (pc_load) begin
                pc_r <= pc_load_value;
            end else if (capture_s) begin
                pc_r <= pc_r + ADDR_W'(1);
            end else begin
                pc_r <= pc_r;
            end
            if (capture_s) begin
                instr_out_r <= read_data;
                instr_pc_r  <= pc_r;
                if (fetch_count_r != 16'hFFFF) begin
                    fetch_count_r <= fetch_count_r + 16'd1;
                end else begin
                    fetch_count_r <= fetch_count_r;
                end
            end else begin
                instr_out_r   <= instr_out_r;
                instr_pc_r    <= instr_pc_r;
                fetch_count_r <= fetch_count_r;
            end
        end
    end

    assign inst_address = pc_r;
    assign instr_out    = instr_out_r;
    assign instr_pc     = instr_pc_r;
    assign instr_valid  = valid_r;
    assign busy         = busy_r;
    assign pc_wrap      = pc_wrap_r;
    assign fetch_count  = fetch_count_r;

endmodule
